// File: rtl/sram_flash_arb.sv
// Two-port Wishbone arbiter/sequencer for the shared ZBT SRAM (port 0) and parallel flash (port 1) pin bus.
// Define SRAM_FLASH_ARB_FLASH_WRITE_EN to let port 1 writes pulse the flash WE pin; otherwise they are acked without pin activity.
module sram_flash_arb #(
    parameter int FLASH_WS = 6
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [20:0] s0_adr_i,
    input  logic [15:0] s0_dat_i,
    output logic [15:0] s0_dat_o,
    input  logic [1:0]  s0_sel_i,
    input  logic        s0_we_i,
    input  logic        s0_stb_i,
    input  logic        s0_cyc_i,
    output logic        s0_ack_o,
    input  logic [20:0] s1_adr_i,
    input  logic [15:0] s1_dat_i,
    output logic [15:0] s1_dat_o,
    input  logic [1:0]  s1_sel_i,
    input  logic        s1_we_i,
    input  logic        s1_stb_i,
    input  logic        s1_cyc_i,
    output logic        s1_ack_o,
    output logic [20:0] sram_flash_addr_,
    inout  wire  [15:0] sram_flash_data_,
    output logic        sram_flash_oe_n_,
    output logic        sram_flash_we_n_,
    output logic [3:0]  sram_bw_,
    output logic        sram_cen_,
    output logic        sram_adv_ld_n_,
    output logic        flash_ce2_
);

`ifdef SRAM_FLASH_ARB_FLASH_WRITE_EN
    localparam bit FLASH_WR_SKIP = 1'b0;
`else
    localparam bit FLASH_WR_SKIP = 1'b1;
`endif

    typedef enum logic [3:0] {
        IDLE, S_ADDR, S_WAIT, S_DATA, S_ACK, F_ACC, F_REC, F_ACK, TURN
    } state_t;

    state_t      state, state_nx;
    logic        last;
    logic        port_q;
    logic        we_q;
    logic [20:0] adr_q;
    logic [15:0] dat_q;
    logic [1:0]  sel_q;
    logic [3:0]  cnt_q;
    logic        abort_q;
    logic        doe_q;

    logic        req0, req1, gnt, grant;
    logic        cur_we;
    logic [20:0] cur_adr;
    logic [15:0] cur_dat;
    logic [1:0]  cur_sel;
    logic        gnt_cyc, abort_now;
    logic        cen_d, oe_n_d, we_n_d, ce2_d, doe_d, ack0_d, ack1_d;
    logic [3:0]  bw_d;

    assign req0  = s0_stb_i & s0_cyc_i;
    assign req1  = s1_stb_i & s1_cyc_i;
    // On a tie the port not served last wins; last resets to 1 so port 0 takes the first tie.
    assign gnt   = (req0 & req1) ? ~last : req1;
    assign grant = (state == IDLE) && (req0 || req1);

    // In IDLE the outputs for the first access cycle come straight from the winning port.
    assign cur_we  = (state == IDLE) ? (gnt ? s1_we_i  : s0_we_i)  : we_q;
    assign cur_adr = (state == IDLE) ? (gnt ? s1_adr_i : s0_adr_i) : adr_q;
    assign cur_dat = (state == IDLE) ? (gnt ? s1_dat_i : s0_dat_i) : dat_q;
    assign cur_sel = (state == IDLE) ? (gnt ? s1_sel_i : s0_sel_i) : sel_q;

    assign gnt_cyc   = port_q ? s1_cyc_i : s0_cyc_i;
    assign abort_now = (state != IDLE) && (abort_q || !gnt_cyc);

    assign sram_adv_ld_n_   = 1'b0;
    assign sram_flash_data_ = doe_q ? dat_q : 16'hzzzz;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cen_d    = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        bw_d     = 4'hF;
        ce2_d    = 1'b0;
        doe_d    = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (!gnt)                          state_nx = S_ADDR;
                    else if (cur_we && FLASH_WR_SKIP)  state_nx = F_ACK;
                    else                               state_nx = F_ACC;
                end
            end
            S_ADDR:  state_nx = S_WAIT;
            S_WAIT:  state_nx = S_DATA;
            S_DATA:  state_nx = S_ACK;
            S_ACK:   state_nx = IDLE;
            F_ACC:   if (cnt_q == 4'd0) state_nx = F_REC;
            F_REC:   state_nx = F_ACK;
            F_ACK:   state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Pin values for the cycle the FSM is about to enter; registered below.
        unique case (state_nx)
            S_ADDR: begin
                cen_d  = 1'b0;
                we_n_d = ~cur_we;
                bw_d   = {2'b11, ~cur_sel};
            end
            S_DATA: begin
                doe_d  = cur_we;
                oe_n_d = cur_we;
            end
            S_ACK:  ack0_d = ~abort_now;
            F_ACC: begin
                ce2_d  = 1'b1;
                doe_d  = cur_we;
                we_n_d = ~cur_we;
                oe_n_d = cur_we;
            end
            F_REC: begin
                ce2_d = 1'b1;
                doe_d = cur_we;
            end
            F_ACK:  ack1_d = ~abort_now;
            default: ;
        endcase
    end

    // Request capture at grant; abort is sticky once the granted cyc drops.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last    <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else if (grant) begin
            last    <= gnt;
            port_q  <= gnt;
            we_q    <= cur_we;
            abort_q <= 1'b0;
            cnt_q   <= 4'(FLASH_WS - 1);
        end else begin
            if (state != IDLE && !gnt_cyc) abort_q <= 1'b1;
            if (state == F_ACC)            cnt_q   <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (grant) begin
            adr_q <= cur_adr;
            dat_q <= cur_dat;
            sel_q <= cur_sel;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sram_flash_addr_ <= 21'd0;
            sram_flash_oe_n_ <= 1'b1;
            sram_flash_we_n_ <= 1'b1;
            sram_bw_         <= 4'hF;
            sram_cen_        <= 1'b1;
            flash_ce2_       <= 1'b0;
            doe_q            <= 1'b0;
            s0_ack_o         <= 1'b0;
            s1_ack_o         <= 1'b0;
            s0_dat_o         <= 16'd0;
            s1_dat_o         <= 16'd0;
        end else begin
            if (state_nx == S_ADDR)     sram_flash_addr_ <= {3'b000, cur_adr[17:0]};
            else if (state_nx == F_ACC && state == IDLE) sram_flash_addr_ <= cur_adr;
            sram_flash_oe_n_ <= oe_n_d;
            sram_flash_we_n_ <= we_n_d;
            sram_bw_         <= bw_d;
            sram_cen_        <= cen_d;
            flash_ce2_       <= ce2_d;
            doe_q            <= doe_d;
            s0_ack_o         <= ack0_d;
            s1_ack_o         <= ack1_d;
            if (state == S_DATA && !we_q && !abort_now)
                s0_dat_o <= sram_flash_data_;
            if (state == F_ACC && cnt_q == 4'd0 && !we_q && !abort_now)
                s1_dat_o <= sram_flash_data_;
        end
    end

endmodule

// File: tb/tb_sram_flash_arb.sv
// Directed bench for sram_flash_arb with a simple ZBT SRAM stub and a constant-output flash stub.
module tb_sram_flash_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] s0_adr, s1_adr;
    logic [15:0] s0_dat_w, s1_dat_w, s0_dat_r, s1_dat_r;
    logic [1:0]  s0_sel, s1_sel;
    logic        s0_we, s1_we, s0_stb, s1_stb, s0_cyc, s1_cyc, s0_ack, s1_ack;
    logic [20:0] addr;
    wire  [15:0] data_bus;
    logic        oe_n, we_n, cen, adv, ce2;
    logic [3:0]  bw;

    int n_checks = 0;
    int n_errors = 0;
    int viol = 0;
    int lat;
    logic mon_en = 1'b0;
    logic probe  = 1'b0;

    logic [15:0] sram_mem [0:255];
    logic [7:0]  alat = 8'd0;
    logic        wlat = 1'b0;
    logic [1:0]  ph   = 2'd0;
    logic [15:0] flash_val = 16'h55AA;
    logic [15:0] stub_rd;

    always #5 clk = ~clk;

    sram_flash_arb #(.FLASH_WS(6)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .s0_adr_i(s0_adr), .s0_dat_i(s0_dat_w), .s0_dat_o(s0_dat_r), .s0_sel_i(s0_sel),
        .s0_we_i(s0_we), .s0_stb_i(s0_stb), .s0_cyc_i(s0_cyc), .s0_ack_o(s0_ack),
        .s1_adr_i(s1_adr), .s1_dat_i(s1_dat_w), .s1_dat_o(s1_dat_r), .s1_sel_i(s1_sel),
        .s1_we_i(s1_we), .s1_stb_i(s1_stb), .s1_cyc_i(s1_cyc), .s1_ack_o(s1_ack),
        .sram_flash_addr_(addr), .sram_flash_data_(data_bus),
        .sram_flash_oe_n_(oe_n), .sram_flash_we_n_(we_n), .sram_bw_(bw),
        .sram_cen_(cen), .sram_adv_ld_n_(adv), .flash_ce2_(ce2)
    );

    // Device stubs: the SRAM returns/stores data two cycles after its address cycle; the flash always returns flash_val.
    // probe makes the bench drive zeros so a stray FPGA drive shows up on the bus.
    assign stub_rd  = ce2 ? flash_val : sram_mem[alat];
    assign data_bus = (oe_n === 1'b0) ? stub_rd : (probe ? 16'h0000 : 16'hzzzz);

    always @(posedge clk) begin
        if (cen === 1'b0) begin
            alat <= addr[7:0];
            wlat <= (we_n === 1'b0);
            ph   <= 2'd1;
        end else if (ph == 2'd1) begin
            ph <= 2'd2;
        end else if (ph == 2'd2) begin
            if (wlat) sram_mem[alat] <= data_bus;
            ph <= 2'd0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (cen === 1'b0 && ce2 === 1'b1) viol++;
            if (oe_n === 1'b0 && data_bus !== stub_rd) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((port == 0 ? s0_ack : s1_ack) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'h1000 + 16'(i);
        rst = 1'b1;
        s0_adr = '0; s0_dat_w = '0; s0_sel = 2'b00; s0_we = 1'b0; s0_stb = 1'b0; s0_cyc = 1'b0;
        s1_adr = '0; s1_dat_w = '0; s1_sel = 2'b00; s1_we = 1'b0; s1_stb = 1'b0; s1_cyc = 1'b0;
        repeat (3) tick();

        // Reset state
        probe = 1'b1;
        check("rst_ack", {30'd0, s0_ack, s1_ack}, 32'd0);
        check("rst_dat", {s0_dat_r, s1_dat_r}, 32'd0);
        check("rst_addr", {11'd0, addr}, 32'd0);
        check("rst_ctl", {26'd0, oe_n, we_n, cen, adv, ce2, 1'b0}, {26'd0, 6'b111000});
        check("rst_bw", {28'd0, bw}, 32'hF);
        check("rst_bus", {16'd0, data_bus}, 32'd0);
        probe = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;

        // Port 0 write 0xBEEF to 0x00123
        s0_adr = 21'h00123; s0_dat_w = 16'hBEEF; s0_sel = 2'b11; s0_we = 1'b1; s0_stb = 1'b1; s0_cyc = 1'b1;
        tick();
        check("s0w_t1_ctl", {28'd0, cen, we_n, oe_n, ce2}, {28'd0, 4'b0010});
        check("s0w_t1_bw", {28'd0, bw}, 32'hC);
        check("s0w_t1_addr", {11'd0, addr}, 32'h00123);
        tick();
        check("s0w_t2_ctl", {30'd0, cen, we_n}, 32'd3);
        tick();
        check("s0w_t3_bus", {15'd0, oe_n, data_bus}, {15'd0, 1'b1, 16'hBEEF});
        tick();
        check("s0w_t4_ack", {30'd0, s0_ack, s1_ack}, 32'd2);
        s0_stb = 1'b0; s0_cyc = 1'b0;
        tick();
        check("s0w_t5_ack", {31'd0, s0_ack}, 32'd0);

        // Port 0 read back
        s0_we = 1'b0; s0_stb = 1'b1; s0_cyc = 1'b1;
        repeat (3) tick();
        check("s0r_t3_oe", {30'd0, oe_n, cen}, 32'd1);
        tick();
        check("s0r_t4", {15'd0, s0_ack, s0_dat_r}, {15'd0, 1'b1, 16'hBEEF});
        s0_stb = 1'b0; s0_cyc = 1'b0;
        tick();

        // Port 1 flash read of 0x1FFFFE
        s1_adr = 21'h1FFFFE; s1_we = 1'b0; s1_sel = 2'b11; s1_stb = 1'b1; s1_cyc = 1'b1;
        tick();
        check("f_rd_addr", {11'd0, addr}, 32'h1FFFFE);
        check("f_rd_acc1", {29'd0, ce2, oe_n, cen}, 32'h5);
        for (int i = 2; i <= 6; i++) begin
            tick();
            check("f_rd_acc", {29'd0, ce2, oe_n, s1_ack}, 32'h4);
        end
        tick();
        check("f_rd_rec", {29'd0, ce2, oe_n, s1_ack}, 32'h6);
        tick();
        check("f_rd_ack", {13'd0, s1_ack, ce2, oe_n, s1_dat_r}, {13'd0, 3'b101, 16'h55AA});
        s1_stb = 1'b0; s1_cyc = 1'b0;
        tick();
        probe = 1'b1;
        check("f_rd_turn", {11'd0, s1_ack, ce2, oe_n, we_n, cen, data_bus}, {11'd0, 5'b00111, 16'h0000});
        probe = 1'b0;

        // Tie after reset: port 0, then port 1, then port 0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s0_adr = 21'h00123; s0_we = 1'b0; s0_stb = 1'b1; s0_cyc = 1'b1;
        s1_adr = 21'h1FFFFE; s1_we = 1'b0; s1_stb = 1'b1; s1_cyc = 1'b1;
        wait_ack(0, 20, lat);
        check("tie1_lat", lat, 4);
        check("tie1_ack1", {31'd0, s1_ack}, 32'd0);
        wait_ack(1, 20, lat);
        check("tie2_lat", lat, 9);
        check("tie2_ack0", {31'd0, s0_ack}, 32'd0);
        s1_stb = 1'b0; s1_cyc = 1'b0;
        wait_ack(0, 20, lat);
        check("tie3_lat", lat, 6);
        check("tie3_dat", {16'd0, s0_dat_r}, 32'hBEEF);
        s0_stb = 1'b0; s0_cyc = 1'b0;
        tick();

        // Port 0 read of 0x124 aborted in S_WAIT
        s0_adr = 21'h00124; s0_we = 1'b0; s0_stb = 1'b1; s0_cyc = 1'b1;
        repeat (2) tick();
        s0_stb = 1'b0; s0_cyc = 1'b0;
        tick();
        check("abort_oe", {31'd0, oe_n}, 32'd0);
        tick();
        check("abort_ack", {31'd0, s0_ack}, 32'd0);
        tick();
        check("abort_dat", {16'd0, s0_dat_r}, 32'hBEEF);

        // Reset during F_ACC, then a fresh SRAM read
        s1_adr = 21'h000100; s1_we = 1'b0; s1_stb = 1'b1; s1_cyc = 1'b1;
        repeat (2) tick();
        rst = 1'b1; s1_stb = 1'b0; s1_cyc = 1'b0;
        tick();
        probe = 1'b1;
        check("rst_facc", {12'd0, ce2, oe_n, cen, s1_ack, data_bus}, {12'd0, 4'b0110, 16'h0000});
        probe = 1'b0;
        rst = 1'b0;
        s0_adr = 21'h00124; s0_we = 1'b0; s0_stb = 1'b1; s0_cyc = 1'b1;
        wait_ack(0, 20, lat);
        check("rst_sram_lat", lat, 4);
        check("rst_sram_dat", {16'd0, s0_dat_r}, 32'h1024);
        s0_stb = 1'b0; s0_cyc = 1'b0;
        tick();

        // Port 1 write 0x00AA to 0x555
        s1_adr = 21'h000555; s1_dat_w = 16'h00AA; s1_we = 1'b1; s1_stb = 1'b1; s1_cyc = 1'b1;
`ifdef SRAM_FLASH_ARB_FLASH_WRITE_EN
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("f_wr_acc", {13'd0, ce2, we_n, oe_n, data_bus}, {13'd0, 3'b101, 16'h00AA});
        end
        tick();
        check("f_wr_rec", {13'd0, ce2, we_n, s1_ack, data_bus}, {13'd0, 3'b110, 16'h00AA});
        tick();
        check("f_wr_ack", {30'd0, s1_ack, ce2}, 32'd2);
`else
        tick();
        probe = 1'b1;
        check("f_wr_skip", {12'd0, s1_ack, ce2, we_n, oe_n, data_bus}, {12'd0, 4'b1011, 16'h0000});
        probe = 1'b0;
`endif
        s1_stb = 1'b0; s1_cyc = 1'b0; s1_we = 1'b0;
        tick();
        check("f_wr_turn", {29'd0, s1_ack, ce2, we_n}, 32'd1);
        tick();

        check("exclusive", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_flash_arb.md
# sram_flash_arb

Two-port Wishbone controller and arbiter for the shared SRAM/flash pin bus of the ML403 board. Port 0 serves the ZBT pipelined SRAM; port 1 serves the asynchronous parallel flash. Both devices share the address, data, OE and WE pins. The block sits between the system Wishbone interconnect and the board pins, and it alone sequences and owns the shared bus.

## Interface
- FLASH_WS, 6: flash access length in clocks (OE or WE low), range 2..15
- wb_clk_i  in  1  system clock; SRAM clock pin is forwarded from it outside this block
- wb_rst_i  in  1  synchronous, active-high reset
- s0_adr_i / s1_adr_i  in  21  word address (SRAM uses [17:0]; flash uses all 21 bits)
- s0_dat_i / s1_dat_i  in  16  write data
- s0_dat_o / s1_dat_o  out  16  read data, registered
- s0_sel_i / s1_sel_i  in  2  byte selects
- s0_we_i / s1_we_i  in  1  write enable
- s0_stb_i / s1_stb_i, s0_cyc_i / s1_cyc_i  in  1  Wishbone strobe and cycle
- s0_ack_o / s1_ack_o  out  1  single-cycle acknowledge
- sram_flash_addr_  out  21  shared address
- sram_flash_data_  inout  16  shared data; driven only while the write-enable register is set
- sram_flash_oe_n_, sram_flash_we_n_  out  1  shared OE and WE, active low
- sram_bw_  out  4  SRAM byte writes, active low; [1:0] = ~sel, [3:2] held at 1
- sram_cen_  out  1  SRAM chip enable, active low
- sram_adv_ld_n_  out  1  SRAM advance/load, held at 0 (load every access)
- flash_ce2_  out  1  flash chip enable, active high

## Operation
- FSM states: IDLE, S_ADDR, S_WAIT, S_DATA, S_ACK, F_ACC, F_REC, F_ACK, TURN.
- IDLE: request = stb & cyc. With one request, grant that port. With both, round-robin: grant the port not granted last. `last` resets to port 1, so port 0 wins the first tie. Address, data, sel and we are latched at grant.
- SRAM sequence:
  - S_ADDR: cen_=0, addr, we_n=~we, bw driven.
  - S_WAIT: cen_=1 (NOP), we_n=1.
  - S_DATA: for a write, data drives the pins. For a read, oe_n=0 and the pins are sampled into s0_dat_o at the end of the cycle.
  - S_ACK: s0_ack_o=1, then IDLE.
- Flash sequence:
  - F_ACC: flash_ce2_=1, addr driven, oe_n=0 for a read or we_n=0 plus data driven for a write, held for FLASH_WS cycles via a 4-bit counter. A read samples the pins on the last F_ACC cycle.
  - F_REC: ce2 still 1, oe_n/we_n=1, data still driven for a write (hold time).
  - F_ACK: s1_ack_o=1, ce2=0. Then TURN: one idle cycle with all strobes inactive and data undriven, then IDLE.
- SRAM accesses never need TURN. After S_ACK the next grant may follow on the very next IDLE cycle.
- Abort: if the granted cyc drops mid-sequence, the pin sequence completes unchanged, the ack is suppressed and dat_o is not updated.
- The ungranted port's ack stays 0. Its request waits in IDLE arbitration.

## Timing
- Reset (synchronous, next edge, from any state): FSM=IDLE, acks 0, dat_o 0, addr 0, data undriven, oe_n=1, we_n=1, bw=4'hF, cen_=1, adv_ld_n_=0, flash_ce2_=0, last=1. A reset mid-sequence truncates the access immediately.
- SRAM: stb seen in cycle T (IDLE) -> S_ADDR in T+1 -> ack in T+4. Back-to-back SRAM accesses start every 5 cycles.
- Flash: stb in T -> F_ACC in T+1..T+FLASH_WS -> F_REC -> ack in T+FLASH_WS+2 -> TURN -> earliest next grant at T+FLASH_WS+4.
- Only one device is ever enabled per cycle: cen_=0 and flash_ce2_=1 never coincide.
- The data bus is never driven by the FPGA in a cycle where oe_n=0.

## Configuration
- SRAM_FLASH_ARB_FLASH_WRITE_EN defined: port 1 writes run the F_ACC write sequence (WE pulse), allowing flash program/erase commands.
- Undefined: port 1 writes cause no pin activity. The FSM goes directly IDLE -> F_ACK, so the ack arrives at T+1, followed by TURN. Flash writes are therefore impossible.

## Test plan
- Port 0 write adr=0x00123, dat=0xBEEF, sel=2'b11 -> cen_=0, we_n=0, bw=4'hC in T+1; data 0xBEEF on the pins in T+3; ack in T+4. A subsequent read returns 0xBEEF.
- Port 1 read adr=0x1FFFFE with FLASH_WS=6 and the stub returning 0x55AA -> ce2=1 and oe_n=0 for 6 cycles; s1_dat_o=0x55AA with ack at T+8; TURN idle at T+9.
- Both ports request in the same cycle after reset -> port 0 is granted first, port 1 is acked next. Repeated ties alternate grants.
- Port 0 drops cyc in S_WAIT -> the pin sequence completes, no s0_ack_o, s0_dat_o unchanged.
- wb_rst_i asserted during F_ACC -> next edge: ce2=0, oe_n=1, data undriven, FSM IDLE; a fresh SRAM read then completes normally.
- Port 1 write 0x00AA to adr 0x555: with the macro, we_n low for FLASH_WS cycles and data held through F_REC; without it, ack at T+1 and the pins stay idle.
